// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-lite arbiter: M0 (CPU) is the default/park master, M1 (DMA/VGA)
// gets the bus at handover points, with a saturating hold counter for fairness.
module mfp_ahb_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       M0_REQ,
    input  logic       M0_LOCK,
    input  logic [1:0] M0_HTRANS,
    input  logic       M1_REQ,
    input  logic       M1_LOCK,
    input  logic [1:0] M1_HTRANS,
    input  logic       HREADY,
    output logic [1:0] HGRANT,
    output logic       HMASTER,
    output logic       HMASTER_D,
    output logic       ARB_SWITCH
);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hmaster_d_q, hmaster_d_d;
    logic             arb_switch_q, arb_switch_d;

    logic       owner_req, owner_lock, other_req;
    logic [1:0] owner_trans;
    logic       handover;

    // Only the owner's LOCK/HTRANS matter; the non-owner contributes just its REQ.
    always_comb begin
        owner_req   = M0_REQ;
        owner_lock  = M0_LOCK;
        owner_trans = M0_HTRANS;
        other_req   = M1_REQ;
        if (state_q == OWN_M1) begin
            owner_req   = M1_REQ;
            owner_lock  = M1_LOCK;
            owner_trans = M1_HTRANS;
            other_req   = M0_REQ;
        end
    end

    assign handover = HREADY && !owner_lock &&
                      ((owner_trans == HTRANS_IDLE) || (owner_trans == HTRANS_NONSEQ));

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        hmaster_d_d  = hmaster_d_q;
        arb_switch_d = 1'b0;

        if (handover) begin
            if (other_req && (!owner_req || (hold_cnt_q == HOLD_MAX))) begin
                state_d = (state_q == OWN_M0) ? OWN_M1 : OWN_M0;
            end else if (!M0_REQ && !M1_REQ) begin
                state_d = OWN_M0;
            end
        end

        if (HREADY) begin
            hmaster_d_d = state_q;
            if (state_d != state_q) begin
                hold_cnt_d   = '0;
                arb_switch_d = 1'b1;
            end else if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= OWN_M0;
            hold_cnt_q   <= '0;
            hmaster_d_q  <= 1'b0;
            arb_switch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            hmaster_d_q  <= hmaster_d_d;
            arb_switch_q <= arb_switch_d;
        end
    end

    assign HMASTER    = state_q;
    assign HGRANT     = {state_q == OWN_M1, state_q == OWN_M0};
    assign HMASTER_D  = hmaster_d_q;
    assign ARB_SWITCH = arb_switch_q;

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// Directed self-checking bench for mfp_ahb_arbiter with hand-computed expectations
// for reset, parking, handover latency, hold fairness, lock/SEQ inhibit and HREADY stalls.
module tb_mfp_ahb_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic       HCLK;
    logic       HRESETn;
    logic       M0_REQ, M0_LOCK, M1_REQ, M1_LOCK, HREADY;
    logic [1:0] M0_HTRANS, M1_HTRANS;
    logic [1:0] HGRANT;
    logic       HMASTER, HMASTER_D, ARB_SWITCH;

    int checks   = 0;
    int failures = 0;

    mfp_ahb_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .M0_REQ     (M0_REQ),
        .M0_LOCK    (M0_LOCK),
        .M0_HTRANS  (M0_HTRANS),
        .M1_REQ     (M1_REQ),
        .M1_LOCK    (M1_LOCK),
        .M1_HTRANS  (M1_HTRANS),
        .HREADY     (HREADY),
        .HGRANT     (HGRANT),
        .HMASTER    (HMASTER),
        .HMASTER_D  (HMASTER_D),
        .ARB_SWITCH (ARB_SWITCH)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Advance one rising edge and settle 1 time unit past it before sampling.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] observed,
                               input logic [1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] grant, input logic mst,
                            input logic mstD, input logic sw);
        checkOutput({tag, ".HGRANT"}, HGRANT, grant);
        checkOutput({tag, ".HMASTER"}, {1'b0, HMASTER}, {1'b0, mst});
        checkOutput({tag, ".HMASTER_D"}, {1'b0, HMASTER_D}, {1'b0, mstD});
        checkOutput({tag, ".ARB_SWITCH"}, {1'b0, ARB_SWITCH}, {1'b0, sw});
    endtask

    initial begin
        HRESETn   = 1'b0;
        M0_REQ    = 1'b0;
        M0_LOCK   = 1'b0;
        M0_HTRANS = IDLE;
        M1_REQ    = 1'b0;
        M1_LOCK   = 1'b0;
        M1_HTRANS = IDLE;
        HREADY    = 1'b1;

        applyStimulus(2);
        checkAll("reset", 2'b01, 1'b0, 1'b0, 1'b0);

        // Idle parking on M0 for 10 cycles; hold counter reaches 10.
        HRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("park.HGRANT", HGRANT, 2'b01);
            checkOutput("park.ARB_SWITCH", {1'b0, ARB_SWITCH}, 2'b00);
        end
        checkOutput("park.HMASTER_D", {1'b0, HMASTER_D}, 2'b00);

        // Both request together while parked: M0 keeps the bus (hold below max).
        M0_REQ    = 1'b1;
        M1_REQ    = 1'b1;
        M0_HTRANS = NONSEQ;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("bothreq.HMASTER", {1'b0, HMASTER}, 2'b00);
        end

        // M0 drops REQ at an IDLE handover point: one-cycle grant latency.
        M0_REQ    = 1'b0;
        M0_HTRANS = IDLE;
        applyStimulus(1);
        checkAll("hand1", 2'b10, 1'b1, 1'b0, 1'b1);
        applyStimulus(1);
        checkAll("hand2", 2'b10, 1'b1, 1'b1, 1'b0);

        // M1 owns (hold=1); M0 requests. Keep through hold 2..16.
        M0_REQ    = 1'b1;
        M1_HTRANS = NONSEQ;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1);
            checkOutput("m1hold.HMASTER", {1'b0, HMASTER}, 2'b01);
        end

        // Saturated, but LOCK inhibits handover; a dropped REQ alone does not switch.
        M1_LOCK = 1'b1;
        applyStimulus(1);
        checkOutput("lock.HMASTER", {1'b0, HMASTER}, 2'b01);
        M1_REQ = 1'b0;
        applyStimulus(1);
        checkOutput("lockreqdrop.HMASTER", {1'b0, HMASTER}, 2'b01);
        M1_REQ = 1'b1;
        applyStimulus(1);
        checkOutput("lock3.HMASTER", {1'b0, HMASTER}, 2'b01);

        // SEQ also inhibits handover.
        M1_LOCK   = 1'b0;
        M1_HTRANS = SEQ;
        applyStimulus(2);
        checkOutput("seq.HMASTER", {1'b0, HMASTER}, 2'b01);
        checkOutput("seq.ARB_SWITCH", {1'b0, ARB_SWITCH}, 2'b00);

        // First NONSEQ cycle with LOCK=0 hands over to M0.
        M1_HTRANS = NONSEQ;
        applyStimulus(1);
        checkAll("unlock", 2'b01, 1'b0, 1'b1, 1'b1);

        // M0 owner with M1 requesting: exactly 16 counted cycles, then switch.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1);
            checkOutput("m0fair.HMASTER", {1'b0, HMASTER}, 2'b00);
        end
        applyStimulus(1);
        checkAll("m0fair.sw", 2'b10, 1'b1, 1'b0, 1'b1);

        // M1 owner; non-owner M0 LOCK/SEQ must be ignored.
        M0_LOCK   = 1'b1;
        M0_HTRANS = SEQ;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1);
            checkOutput("m1fair.HMASTER", {1'b0, HMASTER}, 2'b01);
        end
        applyStimulus(1);
        checkAll("m1fair.sw", 2'b01, 1'b0, 1'b1, 1'b1);

        // Pending handover to M1 frozen by HREADY=0 for 3 cycles.
        M0_LOCK   = 1'b0;
        M0_HTRANS = IDLE;
        M0_REQ    = 1'b0;
        HREADY    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkAll("stall", 2'b01, 1'b0, 1'b1, 1'b0);
        end
        HREADY = 1'b1;
        applyStimulus(1);
        checkAll("stall.sw", 2'b10, 1'b1, 1'b0, 1'b1);
        applyStimulus(1);
        checkAll("stall.after", 2'b10, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while M1 owns.
        #2;
        HRESETn = 1'b0;
        #1;
        checkAll("async", 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1);
        checkAll("inreset", 2'b01, 1'b0, 1'b0, 1'b0);
        HRESETn = 1'b1;
        applyStimulus(1);
        checkAll("regrant", 2'b10, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
